// File: rtl/y_geom_pkg.sv
// Geometry constants and FSM state type shared by the y-coordinate pipeline
// (sqrt stage, y calculation, matrix converter).
package y_geom_pkg;

  localparam int unsigned W     = 12;
  localparam int unsigned OUT_W = 32;
  localparam logic [W-1:0] INVALID = '1;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ITER
  } state_t;

endpackage

// File: rtl/y_sqrt_calc_sqrt_step.sv
// One digit-by-digit square-root iteration: consumes two radicand bits and
// yields the next partial remainder and partial root.
module sqrt_step #(
  parameter int unsigned W = 12
) (
  input  logic [W+1:0] rem_i,
  input  logic [W-1:0] root_i,
  input  logic [1:0]   bits_i,
  output logic [W+1:0] rem_o,
  output logic [W-1:0] root_o
);

  logic [W+1:0] cat;
  logic [W+1:0] trial;

  // Remainder never exceeds 2*root, so W+2 bits hold both the shifted-in
  // value and the signed trial difference without overflow.
  always_comb begin
    cat   = (rem_i << 2) | {{W{1'b0}}, bits_i};
    trial = cat - {root_i, 2'b01};
    if (trial[W+1]) begin
      rem_o  = cat;
      root_o = root_i << 1;
    end else begin
      rem_o  = trial;
      root_o = (root_i << 1) | {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/y_sqrt_calc.sv
// Sequential floor(sqrt(d1^2 - x^2)) producing one root bit per clock;
// invalid geometry yields the saturated INVALID code.
module y_sqrt_calc #(
  parameter int unsigned      W       = y_geom_pkg::W,
  parameter int unsigned      OUT_W   = y_geom_pkg::OUT_W,
  parameter logic [W-1:0]     INVALID = y_geom_pkg::INVALID
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     distance1,
  input  logic [W-1:0]     xValue,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] sqrtY1Value
);

  import y_geom_pkg::*;

  localparam int unsigned CW = $clog2(W);

  state_t           state_q, state_d;
  logic [W-1:0]     d1_q, d1_d;
  logic [W-1:0]     x_q, x_d;
  logic [2*W-1:0]   rad_q, rad_d;
  logic [W+1:0]     rem_q, rem_d;
  logic [W-1:0]     root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] out_q, out_d;

  logic [W+1:0]     step_rem;
  logic [W-1:0]     step_root;
  logic             invalid;
  logic [2*W-1:0]   sq_d1, sq_x;

  sqrt_step #(.W(W)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[2*W-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  assign invalid = (x_q > d1_q) || (d1_q == '0) || (d1_q == INVALID);
  assign sq_d1   = (2*W)'(d1_q) * (2*W)'(d1_q);
  assign sq_x    = (2*W)'(x_q) * (2*W)'(x_q);

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    x_d     = x_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          d1_d    = distance1;
          x_d     = xValue;
          busy_d  = 1'b1;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        if (invalid) begin
          out_d   = OUT_W'(INVALID);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rad_d   = sq_d1 - sq_x;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = CW'(W - 1);
          state_d = ITER;
        end
      end
      ITER: begin
        rad_d  = rad_q << 2;
        rem_d  = step_rem;
        root_d = step_root;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          out_d   = OUT_W'(step_root);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      d1_q    <= '0;
      x_q     <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      x_q     <= x_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sqrtY1Value = out_q;

endmodule

// File: tb/tb_y_sqrt_calc.sv
// Randomized and directed checks of y_sqrt_calc against an arithmetic
// floor-sqrt reference model.
module tb_y_sqrt_calc;

  localparam int W         = 12;
  localparam int LAT_VALID = W + 2;
  localparam int LAT_INV   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] distance1;
  logic [11:0] xValue;
  logic        busy;
  logic        done;
  logic [31:0] sqrtY1Value;

  int checks = 0;
  int errors = 0;

  y_sqrt_calc #(.W(12), .OUT_W(32), .INVALID(12'hFFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .distance1   (distance1),
    .xValue      (xValue),
    .busy        (busy),
    .done        (done),
    .sqrtY1Value (sqrtY1Value)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_invalid(input int d1, input int x);
    return (x > d1) || (d1 == 0) || (d1 == 4095);
  endfunction

  function automatic logic [31:0] ref_root(input int d1, input int x);
    longint rad, r;
    if (is_invalid(d1, x)) return 32'h0000_0FFF;
    rad = longint'(d1) * d1 - longint'(x) * x;
    r = 0;
    while ((r + 1) * (r + 1) <= rad) r++;
    return 32'(r);
  endfunction

  // Drives start for one edge; returns #1 after the accepting edge.
  task automatic issue(input int d1, input int x);
    distance1 = 12'(d1);
    xValue    = 12'(x);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; busy must stay high and the output held.
  task automatic wait_done(output int lat);
    logic [31:0] held;
    bit got;
    held = sqrtY1Value;
    got  = 0;
    lat  = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1;
      else begin
        check_eq("busy_during_op", {31'b0, busy}, 32'd1);
        check_eq("out_held", sqrtY1Value, held);
      end
    end
    if (!got) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input int d1, input int x);
    int lat;
    issue(d1, x);
    check_eq("busy_accept", {31'b0, busy}, 32'd1);
    wait_done(lat);
    // done visible after edge N+lat is sampled at edge N+lat+1
    check_eq("latency", 32'(lat + 1), is_invalid(d1, x) ? 32'(LAT_INV) : 32'(LAT_VALID));
    check_eq("result", sqrtY1Value, ref_root(d1, x));
    check_eq("busy_at_done", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("done_single", {31'b0, done}, 32'd0);
    check_eq("out_after_done", sqrtY1Value, ref_root(d1, x));
  endtask

  initial begin
    int lat, lat2, seen, d1, x;
    reset = 1'b1;
    start = 1'b0;
    distance1 = '0;
    xValue = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_out", sqrtY1Value, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(500, 300);
    run_op(10, 3);
    run_op(250, 250);
    run_op(500, 600);
    run_op(0, 0);
    run_op(4095, 100);
    run_op(4094, 0);
    run_op(1, 0);

    // start while busy is ignored
    issue(1000, 600);
    repeat (4) @(posedge clk);
    #1;
    distance1 = 12'd20;
    xValue    = 12'd30;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check_eq("busy_start_latency", 32'(lat + 6), 32'(LAT_VALID));
    check_eq("busy_start_result", sqrtY1Value, ref_root(1000, 600));
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check_eq("busy_start_no_2nd_done", 32'(seen), 32'd0);

    // start in the done cycle is accepted
    issue(300, 100);
    wait_done(lat);
    check_eq("b2b_first", sqrtY1Value, ref_root(300, 100));
    issue(2000, 1999);
    wait_done(lat2);
    check_eq("b2b_latency", 32'(lat2 + 1), 32'(LAT_VALID));
    check_eq("b2b_second", sqrtY1Value, ref_root(2000, 1999));

    // reset mid-operation aborts
    repeat (3) @(posedge clk);
    #1;
    issue(500, 300);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("midrst_busy", {31'b0, busy}, 32'd0);
    check_eq("midrst_done", {31'b0, done}, 32'd0);
    check_eq("midrst_out", sqrtY1Value, 32'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check_eq("midrst_no_done", 32'(seen), 32'd0);
    run_op(777, 123);

    for (int i = 0; i < 30; i++) begin
      d1 = int'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0: x = int'($urandom_range(0, d1));
        1: x = int'($urandom_range(0, 4095));
        2: x = d1;
        default: x = 0;
      endcase
      run_op(d1, x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
